lc3b_scoreboard: RTL and testbench

//  Producer-side companion to the forwarding path: tracks destination registers of in-flight

---
 rtl/lc3b_scoreboard.sv | 137 +++++++++++++
 tb/tb_lc3b_scoreboard.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lc3b_scoreboard.sv
// Issue-to-writeback destination scoreboard for the LC-3b pipeline: per-register in-flight
// writer counters, a single outstanding-load tracker, and the decode stall decision.
module lc3b_scoreboard #(
   parameter int NREGS  = 8,
   parameter int MAXINF = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     issue_valid_i,
   input  logic                     issue_we_i,
   input  logic [$clog2(NREGS)-1:0] issue_dest_i,
   input  logic                     issue_is_load_i,
   input  logic                     src1_used_i,
   input  logic [$clog2(NREGS)-1:0] src1_i,
   input  logic                     src2_used_i,
   input  logic [$clog2(NREGS)-1:0] src2_i,
   input  logic                     load_done_i,
   input  logic                     wb_valid_i,
   input  logic                     wb_we_i,
   input  logic [$clog2(NREGS)-1:0] wb_dest_i,
   output logic                     stall_o,
   output logic [NREGS-1:0]         pending_o,
   output logic                     load_busy_o
);

   localparam int RW = $clog2(NREGS);
   localparam int CW = $clog2(MAXINF + 1);

   typedef enum logic {
      IDLE      = 1'b0,
      LOAD_PEND = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [RW-1:0]     ld_dest_q, ld_dest_d;
   logic [CW-1:0]     cnt_q [NREGS];
   logic [CW-1:0]     cnt_d [NREGS];
   logic [NREGS-1:0]  pending_q, pending_d;
   logic [NREGS-1:0]  inc_s, dec_s;
   logic              load_wait_s, src_hit_s, sat_s, stall_s;
   logic              accept_s, retire_s, load_issue_s;

   // Stall decision: load-use, second load, or destination counter saturation
   always_comb begin
      load_wait_s = (state_q == LOAD_PEND) && !load_done_i;
      src_hit_s   = (src1_used_i && (src1_i == ld_dest_q)) ||
                    (src2_used_i && (src2_i == ld_dest_q));
      sat_s       = issue_valid_i && issue_we_i && (cnt_q[issue_dest_i] == CW'(MAXINF));
      if (flush_i) begin
         stall_s = 1'b0;
      end else begin
         stall_s = (load_wait_s && src_hit_s) ||
                   (load_wait_s && issue_valid_i && issue_is_load_i) ||
                   sat_s;
      end
      accept_s     = issue_valid_i && !stall_s;
      retire_s     = wb_valid_i && wb_we_i;
      load_issue_s = accept_s && issue_is_load_i && issue_we_i;
   end

   // Per-register counter next state; a retire against an empty counter is dropped
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         inc_s[r] = accept_s && issue_we_i && (issue_dest_i == RW'(r));
         dec_s[r] = retire_s && (wb_dest_i == RW'(r)) && (cnt_q[r] != '0);
         if (flush_i) begin
            cnt_d[r] = '0;
         end else if (inc_s[r] && !dec_s[r]) begin
            cnt_d[r] = cnt_q[r] + CW'(1);
         end else if (dec_s[r] && !inc_s[r]) begin
            cnt_d[r] = cnt_q[r] - CW'(1);
         end else begin
            cnt_d[r] = cnt_q[r];
         end
         pending_d[r] = (cnt_d[r] != '0);
      end
   end

   // Load tracker next state; a load may issue in the very cycle the previous one completes
   always_comb begin
      state_d   = state_q;
      ld_dest_d = ld_dest_q;
      case (state_q)
         IDLE: begin
            if (load_issue_s) begin
               state_d   = LOAD_PEND;
               ld_dest_d = issue_dest_i;
            end else begin
               state_d   = IDLE;
            end
         end
         LOAD_PEND: begin
            if (load_issue_s) begin
               state_d   = LOAD_PEND;
               ld_dest_d = issue_dest_i;
            end else if (load_done_i) begin
               state_d   = IDLE;
            end else begin
               state_d   = LOAD_PEND;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         state_d = state_d;
      end
   end

   // State registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ld_dest_q <= '0;
         pending_q <= '0;
         for (int r = 0; r < NREGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         state_q   <= state_d;
         ld_dest_q <= ld_dest_d;
         pending_q <= pending_d;
         for (int r = 0; r < NREGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   assign stall_o     = stall_s;
   assign pending_o   = pending_q;
   assign load_busy_o = (state_q == LOAD_PEND);

endmodule

// File: tb/tb_lc3b_scoreboard.sv
// Directed, table-driven bench for lc3b_scoreboard with hand-computed expected values.
module tb_lc3b_scoreboard;

   logic       clk;
   logic       rst, flush, iv, iwe, iload, s1u, s2u, ldone, wbv, wbwe;
   logic [2:0] idest, s1, s2, wbdest;
   logic       stall, busy;
   logic [7:0] pend;

   int n_cmp  = 0;
   int n_fail = 0;

   lc3b_scoreboard #(.NREGS(8), .MAXINF(3)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .issue_valid_i(iv), .issue_we_i(iwe), .issue_dest_i(idest), .issue_is_load_i(iload),
      .src1_used_i(s1u), .src1_i(s1), .src2_used_i(s2u), .src2_i(s2),
      .load_done_i(ldone), .wb_valid_i(wbv), .wb_we_i(wbwe), .wb_dest_i(wbdest),
      .stall_o(stall), .pending_o(pend), .load_busy_o(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst, flush, iv, iwe;
      logic [2:0] idest;
      logic       iload, s1u;
      logic [2:0] s1;
      logic       s2u;
      logic [2:0] s2;
      logic       ldone, wbv, wbwe;
      logic [2:0] wbdest;
      logic       exp_stall;
      logic [7:0] exp_pend;
      logic       exp_busy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(string nm, int r, int f, int v, int we, int d, int ld,
                               int u1, int a1, int u2, int a2, int dn, int wv, int ww,
                               int wd, int st, int pd, int bz);
      vec_t x;
      x.name = nm; x.rst = r[0]; x.flush = f[0]; x.iv = v[0]; x.iwe = we[0];
      x.idest = d[2:0]; x.iload = ld[0]; x.s1u = u1[0]; x.s1 = a1[2:0];
      x.s2u = u2[0]; x.s2 = a2[2:0]; x.ldone = dn[0]; x.wbv = wv[0]; x.wbwe = ww[0];
      x.wbdest = wd[2:0]; x.exp_stall = st[0]; x.exp_pend = pd[7:0]; x.exp_busy = bz[0];
      return x;
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic quiet();
      rst = 0; flush = 0; iv = 0; iwe = 0; idest = 0; iload = 0; s1u = 0; s1 = 0;
      s2u = 0; s2 = 0; ldone = 0; wbv = 0; wbwe = 0; wbdest = 0;
   endtask

   // Inputs are already driven after a negedge: check stall, clock, then check registered outputs
   task automatic cyc(string nm, logic es, logic [7:0] ep, logic eb);
      #2;
      chk({nm, ".stall"}, int'(stall), int'(es));
      @(posedge clk);
      #1;
      chk({nm, ".pending"}, int'(pend), int'(ep));
      chk({nm, ".load_busy"}, int'(busy), int'(eb));
      @(negedge clk);
   endtask

   task automatic apply(vec_t x);
      rst = x.rst; flush = x.flush; iv = x.iv; iwe = x.iwe; idest = x.idest; iload = x.iload;
      s1u = x.s1u; s1 = x.s1; s2u = x.s2u; s2 = x.s2; ldone = x.ldone;
      wbv = x.wbv; wbwe = x.wbwe; wbdest = x.wbdest;
   endtask

   initial begin
      //            name      rst fl iv we d ld u1 a1 u2 a2 dn wv ww wd  st  pend busy
      tbl.push_back(mk("alu_iss",  0,0, 1,1,3,0, 0,0, 0,0, 0, 0,0,0, 0, 8'h08, 0));
      tbl.push_back(mk("alu_use",  0,0, 0,0,0,0, 1,3, 0,0, 0, 0,0,0, 0, 8'h08, 0));
      tbl.push_back(mk("alu_wb",   0,0, 0,0,0,0, 0,0, 0,0, 0, 1,1,3, 0, 8'h00, 0));
      tbl.push_back(mk("ld_iss",   0,0, 1,1,2,1, 0,0, 0,0, 0, 0,0,0, 0, 8'h04, 1));
      tbl.push_back(mk("ld_use1",  0,0, 1,1,7,0, 0,0, 1,2, 0, 0,0,0, 1, 8'h04, 1));
      tbl.push_back(mk("ld_use2",  0,0, 1,1,7,0, 0,0, 1,2, 0, 0,0,0, 1, 8'h04, 1));
      tbl.push_back(mk("ld_done",  0,0, 1,1,7,0, 0,0, 1,2, 1, 0,0,0, 0, 8'h84, 0));
      tbl.push_back(mk("ld_wb2",   0,0, 0,0,0,0, 0,0, 0,0, 0, 1,1,2, 0, 8'h80, 0));
      tbl.push_back(mk("ld_wb7",   0,0, 0,0,0,0, 0,0, 0,0, 0, 1,1,7, 0, 8'h00, 0));
      tbl.push_back(mk("sim_iss",  0,0, 1,1,5,0, 0,0, 0,0, 0, 0,0,0, 0, 8'h20, 0));
      tbl.push_back(mk("sim_both", 0,0, 1,1,5,0, 0,0, 0,0, 0, 1,1,5, 0, 8'h20, 0));
      tbl.push_back(mk("sim_wb6",  0,0, 0,0,0,0, 0,0, 0,0, 0, 1,1,6, 0, 8'h20, 0));
      tbl.push_back(mk("sim_wb5",  0,0, 0,0,0,0, 0,0, 0,0, 0, 1,1,5, 0, 8'h00, 0));
      tbl.push_back(mk("fl_r0a",   0,0, 1,1,0,0, 0,0, 0,0, 0, 0,0,0, 0, 8'h01, 0));
      tbl.push_back(mk("fl_r0b",   0,0, 1,1,0,0, 0,0, 0,0, 0, 0,0,0, 0, 8'h01, 0));
      tbl.push_back(mk("fl_ld4",   0,0, 1,1,4,1, 0,0, 0,0, 0, 0,0,0, 0, 8'h11, 1));
      tbl.push_back(mk("fl_flush", 0,1, 1,1,4,1, 1,4, 0,0, 0, 0,0,0, 0, 8'h00, 0));
      tbl.push_back(mk("fl_after", 0,0, 0,0,0,0, 1,4, 0,0, 0, 0,0,0, 0, 8'h00, 0));
      tbl.push_back(mk("uf_wb0",   0,0, 0,0,0,0, 0,0, 0,0, 0, 1,1,0, 0, 8'h00, 0));
      tbl.push_back(mk("uf_iss0",  0,0, 1,1,0,0, 0,0, 0,0, 0, 0,0,0, 0, 8'h01, 0));
      tbl.push_back(mk("uf_ret0",  0,0, 0,0,0,0, 0,0, 0,0, 0, 1,1,0, 0, 8'h00, 0));
      tbl.push_back(mk("l2_iss1",  0,0, 1,1,1,1, 0,0, 0,0, 0, 0,0,0, 0, 8'h02, 1));
      tbl.push_back(mk("l2_block", 0,0, 1,1,6,1, 0,0, 0,0, 0, 0,0,0, 1, 8'h02, 1));
      tbl.push_back(mk("l2_chain", 0,0, 1,1,6,1, 0,0, 0,0, 1, 0,0,0, 0, 8'h42, 1));
      tbl.push_back(mk("l2_use6",  0,0, 0,0,0,0, 1,6, 0,0, 0, 0,0,0, 1, 8'h42, 1));
      tbl.push_back(mk("l2_use1",  0,0, 0,0,0,0, 1,1, 0,0, 0, 0,0,0, 0, 8'h42, 1));
      tbl.push_back(mk("l2_done",  0,0, 0,0,0,0, 0,0, 0,0, 1, 1,1,1, 0, 8'h40, 0));
      tbl.push_back(mk("l2_wb6",   0,0, 0,0,0,0, 0,0, 0,0, 0, 1,1,6, 0, 8'h00, 0));
      tbl.push_back(mk("nowe_iss", 0,0, 1,1,3,0, 0,0, 0,0, 0, 0,0,0, 0, 8'h08, 0));
      tbl.push_back(mk("nowe_wb",  0,0, 0,0,0,0, 0,0, 0,0, 0, 1,0,3, 0, 8'h08, 0));
      tbl.push_back(mk("nowe_ret", 0,0, 0,0,0,0, 0,0, 0,0, 0, 1,1,3, 0, 8'h00, 0));
      tbl.push_back(mk("rp_iss2",  0,0, 1,1,2,1, 0,0, 0,0, 0, 0,0,0, 0, 8'h04, 1));
      tbl.push_back(mk("rp_rstfl", 1,1, 0,0,0,0, 0,0, 0,0, 0, 0,0,0, 0, 8'h00, 0));

      // Reset with random inputs held for three edges
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         {flush, iv, iwe, iload, s1u, s2u, ldone, wbv, wbwe} = 9'($urandom);
         {idest, s1, s2, wbdest} = 12'($urandom);
         rst = 1'b1;
         @(posedge clk);
         #1;
         @(negedge clk);
      end
      chk("reset.pending", int'(pend), 0);
      chk("reset.load_busy", int'(busy), 0);
      quiet();
      iv = 1'b1; iwe = 1'b1; iload = 1'b1; s1u = 1'b1; s2u = 1'b1; idest = 3'd4;
      #2;
      chk("reset.stall", int'(stall), 0);
      quiet();

      foreach (tbl[i]) begin
         apply(tbl[i]);
         cyc(tbl[i].name, tbl[i].exp_stall, tbl[i].exp_pend, tbl[i].exp_busy);
      end

      // Saturation on R1: three in-flight writers, fourth is held until one retires
      quiet();
      for (int i = 0; i < 3; i++) begin
         iv = 1'b1; iwe = 1'b1; idest = 3'd1;
         cyc("sat_fill", 1'b0, 8'h02, 1'b0);
      end
      cyc("sat_hold", 1'b1, 8'h02, 1'b0);
      wbv = 1'b1; wbwe = 1'b1; wbdest = 3'd1;
      cyc("sat_retire", 1'b1, 8'h02, 1'b0);
      wbv = 1'b0; wbwe = 1'b0;
      cyc("sat_accept", 1'b0, 8'h02, 1'b0);
      cyc("sat_full", 1'b1, 8'h02, 1'b0);
      quiet();
      wbv = 1'b1; wbwe = 1'b1; wbdest = 3'd1;
      cyc("sat_drain1", 1'b0, 8'h02, 1'b0);
      cyc("sat_drain2", 1'b0, 8'h02, 1'b0);
      cyc("sat_drain3", 1'b0, 8'h00, 1'b0);
      quiet();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
